// File: rtl/alu_cla_sched_pkg.sv
// Shared state encoding, default widths and pointer helper for the ALU scheduler.
// Pure declarations: no latency, no flow control.
package alu_cla_sched_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_OP_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/alu_cla_sched_if.sv
// Request, response and ALU-side bundle for the scheduler; master = clients/ALU side, slave = scheduler.
// Wires only: valid/ready on requests and responses, ALU side is plain combinational.
interface alu_cla_sched_if
  import alu_cla_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int OP_W    = DEF_OP_W,
  parameter int ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_operand1;
  logic [NUM_REQ*DATA_W-1:0] req_operand2;
  logic [NUM_REQ*OP_W-1:0]   req_opcode;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_result;
  logic                      rsp_carry_out;
  logic [2*DATA_W-1:0]       rsp_product;

  logic [DATA_W-1:0]         alu_operand1;
  logic [DATA_W-1:0]         alu_operand2;
  logic [OP_W-1:0]           alu_opcode;
  logic [DATA_W-1:0]         alu_result;
  logic                      alu_carry_out;
  logic [2*DATA_W-1:0]       alu_product;

  modport master (
    output req_valid, req_operand1, req_operand2, req_opcode, rsp_ready,
           alu_result, alu_carry_out, alu_product,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry_out, rsp_product,
           alu_operand1, alu_operand2, alu_opcode
  );

  modport slave (
    input  req_valid, req_operand1, req_operand2, req_opcode, rsp_ready,
           alu_result, alu_carry_out, alu_product,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry_out, rsp_product,
           alu_operand1, alu_operand2, alu_opcode
  );

endinterface

// File: rtl/alu_cla_sched_rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping; zero grant when disabled.
// No latency; no backpressure of its own.
module alu_cla_sched_rr_arbiter
  import alu_cla_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  int   idx;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (enable && !found && req[idx]) begin
        found     = 1'b1;
        grant[idx] = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_cla_sched.sv
// Round-robin scheduler sharing one ALU among NUM_REQ requesters; grant edge to rsp_valid is 2 cycles.
// Response is held in RESP until rsp_ready; no request is granted outside IDLE.
module alu_cla_sched
  import alu_cla_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int OP_W    = DEF_OP_W,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_cla_sched_if.slave   bus,
  output logic             busy
);

  typedef struct packed {
    logic [DATA_W-1:0]   result;
    logic                carry_out;
    logic [2*DATA_W-1:0] product;
  } rsp_t;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q;
  logic [ID_W-1:0]     id_q;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                arb_en;
  logic                req_fire;
  logic                rsp_fire;
  logic                rsp_valid_q;
  rsp_t                rsp_q;
  logic [DATA_W-1:0]   alu_op1_q;
  logic [DATA_W-1:0]   alu_op2_q;
  logic [OP_W-1:0]     alu_opc_q;

  // Gating with rst_n keeps req_ready low for the whole reset cycle.
  assign arb_en = rst_n && (state_q == IDLE);

  alu_cla_sched_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req       (bus.req_valid),
    .ptr       (ptr_q),
    .enable    (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_fire = |grant;
  assign rsp_fire = rsp_valid_q && bus.rsp_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_fire) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      alu_op1_q   <= '0;
      alu_op2_q   <= '0;
      alu_opc_q   <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_fire) begin
        alu_op1_q <= bus.req_operand1[int'(grant_idx)*DATA_W +: DATA_W];
        alu_op2_q <= bus.req_operand2[int'(grant_idx)*DATA_W +: DATA_W];
        alu_opc_q <= bus.req_opcode[int'(grant_idx)*OP_W +: OP_W];
        id_q      <= grant_idx;
      end
      if (state_q == EXEC) begin
        rsp_q       <= '{result: bus.alu_result, carry_out: bus.alu_carry_out,
                         product: bus.alu_product};
        rsp_valid_q <= 1'b1;
      end
      // Pointer moves past the served requester only once its response has left.
      if (state_q == RESP && rsp_fire) begin
        rsp_valid_q <= 1'b0;
        ptr_q       <= ID_W'(next_idx(int'(id_q), NUM_REQ));
      end
    end
  end

  assign bus.req_ready     = grant;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_id        = id_q;
  assign bus.rsp_result    = rsp_q.result;
  assign bus.rsp_carry_out = rsp_q.carry_out;
  assign bus.rsp_product   = rsp_q.product;
  assign bus.alu_operand1  = alu_op1_q;
  assign bus.alu_operand2  = alu_op2_q;
  assign bus.alu_opcode    = alu_opc_q;
  assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_alu_cla_sched.sv
// Scoreboard bench for alu_cla_sched: random and directed requests against a round-robin timing model.
module tb_alu_cla_sched;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int OP_W    = 4;
  localparam int ID_W    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_cla_sched_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .OP_W(OP_W), .ID_W(ID_W)) bus ();

  alu_cla_sched #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .OP_W(OP_W), .ID_W(ID_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  // ALU stub: add with carry and full-width multiply
  logic [DATA_W:0] alu_sum;
  assign alu_sum           = {1'b0, bus.alu_operand1} + {1'b0, bus.alu_operand2};
  assign bus.alu_result    = alu_sum[DATA_W-1:0];
  assign bus.alu_carry_out = alu_sum[DATA_W];
  assign bus.alu_product   = {{DATA_W{1'b0}}, bus.alu_operand1} * {{DATA_W{1'b0}}, bus.alu_operand2};

  typedef struct {
    int               id;
    logic [31:0]      res;
    logic             cy;
    logic [63:0]      prod;
  } exp_t;

  exp_t             sb[$];
  logic [31:0]      p_op1 [NUM_REQ];
  logic [31:0]      p_op2 [NUM_REQ];
  logic [3:0]       p_opc [NUM_REQ];
  logic [NUM_REQ-1:0] accepted_mask = '0;
  int               acc_cnt [NUM_REQ];

  // Model: one operation outstanding at a time; 'age' counts cycles since the accepting edge.
  bit               m_out = 1'b0;
  int               m_age = 0;
  int               m_ptr = 0;
  int               pick;
  logic [NUM_REQ-1:0] exp_rdy;
  bit               exp_vld;
  exp_t             e;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event not seen, expected it (t=%0t)", nm, $time);
  endtask

  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int p);
    for (int k = 0; k < NUM_REQ; k++)
      if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    return -1;
  endfunction

  function automatic exp_t make_exp(input int id, input logic [31:0] a, input logic [31:0] b);
    exp_t x;
    logic [63:0] s;
    s      = 64'(a) + 64'(b);
    x.id   = id;
    x.res  = s[31:0];
    x.cy   = s[32];
    x.prod = 64'(a) * 64'(b);
    return x;
  endfunction

  always @(negedge clk) begin
    if (m_out) m_age++;
    exp_vld = m_out && (m_age >= 2);
    chk("rsp_valid", bus.rsp_valid, exp_vld);
    chk("busy", busy, m_out && (m_age >= 1));

    pick    = (!m_out && rst_n) ? rr_pick(bus.req_valid, m_ptr) : -1;
    exp_rdy = '0;
    if (pick >= 0) exp_rdy[pick] = 1'b1;
    chk("req_ready", bus.req_ready, exp_rdy);

    accepted_mask = bus.req_valid & bus.req_ready & {NUM_REQ{rst_n}};
    for (int i = 0; i < NUM_REQ; i++) if (accepted_mask[i]) acc_cnt[i]++;

    if (bus.rsp_valid) begin
      if (sb.size() == 0) begin
        fail("spurious_rsp");
      end else begin
        chk("rsp_id", bus.rsp_id, sb[0].id);
        chk("rsp_result", bus.rsp_result, sb[0].res);
        chk("rsp_carry", bus.rsp_carry_out, sb[0].cy);
        chk("rsp_product", bus.rsp_product, sb[0].prod);
      end
    end
    if (exp_vld && bus.rsp_ready && rst_n && sb.size() > 0) begin
      m_ptr = (sb[0].id + 1) % NUM_REQ;
      void'(sb.pop_front());
      m_out = 1'b0;
    end

    if (pick >= 0) begin
      e = make_exp(pick, p_op1[pick], p_op2[pick]);
      sb.push_back(e);
      m_out = 1'b1;
      m_age = 0;
    end

    if (!rst_n) begin
      m_out = 1'b0;
      m_age = 0;
      m_ptr = 0;
      sb.delete();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    p_op1[i] = a;
    p_op2[i] = b;
    p_opc[i] = c;
    bus.req_operand1[i*DATA_W +: DATA_W] = a;
    bus.req_operand2[i*DATA_W +: DATA_W] = b;
    bus.req_opcode[i*OP_W +: OP_W]       = c;
    bus.req_valid[i] = 1'b1;
  endtask

  task automatic drop(input int i);
    bus.req_valid[i] = 1'b0;
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_accept(input int i);
    bit ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (accepted_mask[i]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail($sformatf("accept_timeout_req%0d", i));
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int n = 0; n < 80; n++) begin
      tick();
      if (!m_out && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("idle_timeout");
  endtask

  task automatic wait_rsp_check(input string nm, input int id, input logic [31:0] res,
                                input logic cy, input logic [63:0] prod);
    bit ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (bus.rsp_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      fail({nm, "_rsp_timeout"});
    end else begin
      chk({nm, "_id"}, bus.rsp_id, id);
      chk({nm, "_result"}, bus.rsp_result, res);
      chk({nm, "_carry"}, bus.rsp_carry_out, cy);
      chk({nm, "_product"}, bus.rsp_product, prod);
    end
  endtask

  int g_ids[$];
  int g_cyc[$];
  int exp_order[5] = '{0, 1, 2, 3, 0};
  int req1_before;

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      acc_cnt[i] = 0;
      set_req(i, '0, '0, '0);
      drop(i);
    end
    bus.rsp_ready = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_alu_operand1", bus.alu_operand1, 0);
    chk("rst_alu_operand2", bus.alu_operand2, 0);
    chk("rst_alu_opcode", bus.alu_opcode, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_rsp_result", bus.rsp_result, 0);
    chk("rst_rsp_carry", bus.rsp_carry_out, 0);
    chk("rst_rsp_product", bus.rsp_product, 0);
    tick();
    rst_n = 1'b1;

    // Single request from requester 0
    tick();
    set_req(0, 32'd8, 32'd8, 4'd0);
    wait_accept(0);
    drop(0);
    wait_rsp_check("single", 0, 32'd16, 1'b0, 64'd64);
    wait_idle();

    // All requesters valid from a fresh pointer
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, rnd_op(), rnd_op(), 4'($urandom_range(0, 15)));
    for (int n = 0; n < 60 && g_ids.size() < 5; n++) begin
      tick();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accepted_mask[i]) begin
          g_ids.push_back(i);
          g_cyc.push_back(cyc);
          set_req(i, rnd_op(), rnd_op(), 4'($urandom_range(0, 15)));
        end
      end
    end
    for (int i = 0; i < NUM_REQ; i++) drop(i);
    if (g_ids.size() < 5) begin
      fail("grant_sequence_short");
    end else begin
      for (int k = 0; k < 5; k++) chk($sformatf("grant_order_%0d", k), g_ids[k], exp_order[k]);
      for (int k = 1; k < 5; k++) chk($sformatf("issue_interval_%0d", k), g_cyc[k] - g_cyc[k-1], 3);
    end
    wait_idle();

    // Backpressure with a requester that withdraws while the response is stalled
    bus.rsp_ready = 1'b0;
    set_req(2, rnd_op(), rnd_op(), 4'd5);
    wait_accept(2);
    drop(2);
    for (int n = 0; n < 10 && !bus.rsp_valid; n++) tick();
    req1_before = acc_cnt[1];
    set_req(1, rnd_op(), rnd_op(), 4'd1);
    tick();
    drop(1);
    repeat (4) begin
      tick();
      chk("bp_busy", busy, 1);
      chk("bp_req_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    wait_idle();
    repeat (3) tick();
    chk("withdrawn_req1_grants", acc_cnt[1] - req1_before, 0);

    // Carry boundary
    set_req(0, 32'hFFFF_FFFF, 32'd1, 4'd0);
    wait_accept(0);
    drop(0);
    wait_rsp_check("carry", 0, 32'd0, 1'b1, 64'h0000_0000_FFFF_FFFF);
    wait_idle();

    // Reset while EXEC: operation discarded, pointer back to 0
    set_req(1, rnd_op(), rnd_op(), 4'd2);
    wait_accept(1);
    rst_n = 1'b0;
    drop(1);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    set_req(0, 32'd3, 32'd4, 4'd0);
    set_req(2, 32'd5, 32'd7, 4'd0);
    wait_accept(0);
    drop(0);
    wait_rsp_check("post_rst_req0", 0, 32'd7, 1'b0, 64'd12);
    wait_accept(2);
    drop(2);
    wait_rsp_check("post_rst_req2", 2, 32'd12, 1'b0, 64'd35);
    wait_idle();

    // Randomized traffic with random response backpressure
    for (int n = 0; n < 500; n++) begin
      tick();
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accepted_mask[i] || !bus.req_valid[i]) begin
          if ($urandom_range(0, 2) != 0) set_req(i, rnd_op(), rnd_op(), 4'($urandom_range(0, 15)));
          else drop(i);
        end else if ($urandom_range(0, 9) == 0) begin
          drop(i);
        end
      end
    end
    for (int i = 0; i < NUM_REQ; i++) drop(i);
    bus.rsp_ready = 1'b1;
    wait_idle();
    repeat (3) tick();
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
